// File: rtl/cobro_seleccion.sv
// cobro_seleccion: coin collection and drink selection controller. Ports: clk/rst (sync, active-high); moneda coin in; boton drink request; cancelar refund request; finish from preparation; sel drink code out; credito current credit; cambio/cambio_valid change pulse; rechazo coin rejected; insuficiente price above credit; ocupado not idle; falla watchdog fault. Optional macro COBRO_TIMEOUT_EN adds the PREPARANDO watchdog and FALLA state.
module cobro_seleccion #(
  parameter int CREDITO_MAX    = 15,
  parameter int PRECIO_1       = 3,
  parameter int PRECIO_2       = 4,
  parameter int PRECIO_3       = 4,
  parameter int PRECIO_4       = 5,
  parameter int TIMEOUT_CICLOS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] moneda,
  input  logic [2:0] boton,
  input  logic       cancelar,
  input  logic       finish,
  output logic [2:0] sel,
  output logic [7:0] credito,
  output logic [7:0] cambio,
  output logic       cambio_valid,
  output logic       rechazo,
  output logic       insuficiente,
  output logic       ocupado,
  output logic       falla
);
  typedef enum logic [2:0] {
    ESPERA,
    DESPACHO,
    PREPARANDO,
    CAMBIO
`ifdef COBRO_TIMEOUT_EN
    , FALLA
`endif
  } estado_t;
  localparam logic [7:0] CMAX = 8'(CREDITO_MAX);
  localparam logic [7:0] P1 = 8'(PRECIO_1);
  localparam logic [7:0] P2 = 8'(PRECIO_2);
  localparam logic [7:0] P3 = 8'(PRECIO_3);
  localparam logic [7:0] P4 = 8'(PRECIO_4);
  estado_t    r_estado, w_sig;
  logic [7:0] r_credito, r_cambio, r_dev;
  logic [2:0] r_cod;
  logic       r_dev_v, r_cnt_d;
  logic [7:0] w_val, w_precio, w_suma;
  logic       w_bval, w_esp, w_cancel, w_compra, w_acepta, w_fpulse;
  assign w_val    = moneda == 2'b11 ? 8'd5 : {6'd0, moneda};
  assign w_precio = boton == 3'd1 ? P1 : boton == 3'd2 ? P2 : boton == 3'd3 ? P3 : boton == 3'd4 ? P4 : 8'd0;
  assign w_bval   = boton != 3'd0 && boton <= 3'd4;
  assign w_suma   = r_credito + w_val;
  // cancelar dominates boton, which dominates moneda; a coin is only taken when neither is present
  assign w_esp    = r_estado == ESPERA && !rst;
  assign w_cancel = w_esp && cancelar;
  assign w_compra = w_esp && !cancelar && w_bval && w_precio <= r_credito;
  assign w_acepta = w_esp && !cancelar && !w_bval && moneda != 2'b00 && w_suma <= CMAX;
  assign rechazo      = !rst && moneda != 2'b00 && !w_acepta;
  assign insuficiente = w_esp && !cancelar && w_bval && w_precio > r_credito;
  assign sel          = r_estado == DESPACHO ? r_cod : 3'd0;
  assign credito      = r_credito;
  assign ocupado      = r_estado != ESPERA;
  assign cambio_valid = r_estado == CAMBIO || r_dev_v || w_fpulse;
`ifdef COBRO_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic [7:0]  r_precio;
  logic        r_fdone;
  // the refund pulse fires only on the first FALLA cycle
  assign w_fpulse = r_estado == FALLA && !r_fdone;
  assign falla    = r_estado == FALLA;
  assign cambio   = r_estado == CAMBIO ? r_cambio : w_fpulse ? r_cambio + r_precio : r_dev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_precio <= '0;
      r_fdone  <= 1'b0;
    end else begin
      r_cnt    <= r_estado == PREPARANDO ? r_cnt + 16'd1 : 16'd0;
      r_precio <= w_compra ? w_precio : r_precio;
      r_fdone  <= r_estado == FALLA;
    end
  end
`else
  assign w_fpulse = 1'b0;
  assign falla    = TIMEOUT_CICLOS < 0;
  assign cambio   = r_estado == CAMBIO ? r_cambio : r_dev;
`endif
  always_comb begin
    w_sig = r_estado;
    unique case (r_estado)
      ESPERA:     w_sig = w_compra ? DESPACHO : ESPERA;
      DESPACHO:   w_sig = r_cnt_d ? PREPARANDO : DESPACHO;
`ifdef COBRO_TIMEOUT_EN
      PREPARANDO: w_sig = finish ? CAMBIO : r_cnt == 16'(TIMEOUT_CICLOS - 1) ? FALLA : PREPARANDO;
      FALLA:      w_sig = FALLA;
`else
      PREPARANDO: w_sig = finish ? CAMBIO : PREPARANDO;
`endif
      CAMBIO:     w_sig = ESPERA;
      default:    w_sig = ESPERA;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado  <= ESPERA;
      r_credito <= '0;
      r_cambio  <= '0;
      r_cod     <= '0;
      r_dev     <= '0;
      r_dev_v   <= 1'b0;
      r_cnt_d   <= 1'b0;
    end else begin
      r_estado  <= w_sig;
      r_credito <= w_cancel || w_compra ? 8'd0 : w_acepta ? w_suma : r_credito;
      r_cambio  <= w_compra ? r_credito - w_precio : r_cambio;
      r_cod     <= w_compra ? boton : r_cod;
      r_dev     <= w_cancel ? r_credito : 8'd0;
      r_dev_v   <= w_cancel && r_credito != 8'd0;
      r_cnt_d   <= r_estado == DESPACHO && !r_cnt_d;
    end
  end
endmodule

// File: tb/tb_cobro_seleccion.sv
// tb_cobro_seleccion: directed and random check of cobro_seleccion against a transaction-level model
module tb_cobro_seleccion;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] moneda;
  logic [2:0] boton;
  logic       cancelar, finish;
  logic [2:0] sel;
  logic [7:0] credito, cambio;
  logic       cambio_valid, rechazo, insuficiente, ocupado, falla;
  int n_chk = 0;
  int n_err = 0;
  int m_cred, m_disp, m_code, m_change, m_paid, m_dev, m_wait_n;
  bit m_wait, m_cobro, m_dev_v, m_fall, m_fpulse;
  cobro_seleccion #(.TIMEOUT_CICLOS(10)) dut (
    .clk(clk), .rst(rst), .moneda(moneda), .boton(boton), .cancelar(cancelar), .finish(finish),
    .sel(sel), .credito(credito), .cambio(cambio), .cambio_valid(cambio_valid), .rechazo(rechazo),
    .insuficiente(insuficiente), .ocupado(ocupado), .falla(falla)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int precio(input int b);
    int tabla[5] = '{0, 3, 4, 4, 5};
    return (b >= 1 && b <= 4) ? tabla[b] : 0;
  endfunction
  task automatic model_reset();
    m_cred = 0; m_disp = 0; m_code = 0; m_change = 0; m_paid = 0; m_dev = 0; m_wait_n = 0;
    m_wait = 0; m_cobro = 0; m_dev_v = 0; m_fall = 0; m_fpulse = 0;
  endtask
  task automatic paso(input int m, input int b, input bit c, input bit f, input bit r);
    int v, p, e_sel, e_cv, e_camb;
    bit idle, validb, take, e_rech, e_ins;
    moneda = 2'(m); boton = 3'(b); cancelar = c; finish = f; rst = r;
    #1;
    v = (m == 3) ? 5 : m;
    p = precio(b);
    validb = b >= 1 && b <= 4;
    idle = !(m_disp > 0 || m_wait || m_cobro || m_fall);
    take = !r && idle && !c && !validb && m != 0 && m_cred + v <= 15;
    e_rech = !r && m != 0 && !take;
    e_ins = !r && idle && !c && validb && p > m_cred;
    e_sel = m_disp > 0 ? m_code : 0;
    e_cv = m_cobro || m_dev_v || m_fpulse;
    e_camb = m_cobro ? m_change : m_fpulse ? m_paid : m_dev;
    chk("credito", credito, m_cred);
    chk("sel", sel, e_sel);
    chk("ocupado", ocupado, !idle);
    chk("cambio_valid", cambio_valid, e_cv);
    if (e_cv) chk("cambio", cambio, e_camb);
    chk("rechazo", rechazo, e_rech);
    chk("insuficiente", insuficiente, e_ins);
    chk("falla", falla, m_fall);
    if (r) model_reset();
    else begin
      m_dev_v = 0; m_dev = 0; m_fpulse = 0;
      if (m_fall) ;
      else if (m_cobro) m_cobro = 0;
      else if (m_wait) begin
        m_wait_n++;
        if (f) begin m_wait = 0; m_cobro = 1; end
`ifdef COBRO_TIMEOUT_EN
        else if (m_wait_n == 10) begin m_wait = 0; m_fall = 1; m_fpulse = 1; end
`endif
      end else if (m_disp > 0) begin
        m_disp--;
        if (m_disp == 0) begin m_wait = 1; m_wait_n = 0; end
      end else if (c) begin
        m_dev_v = m_cred > 0; m_dev = m_cred; m_cred = 0;
      end else if (validb && p <= m_cred) begin
        m_code = b; m_change = m_cred - p; m_paid = m_cred; m_cred = 0; m_disp = 2;
      end else if (take) m_cred += v;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; moneda = 0; boton = 0; cancelar = 0; finish = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_credito", credito, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cv", cambio_valid, 0);
    paso(3, 0, 0, 0, 0);
    paso(1, 0, 0, 0, 0);
    chk("d_cred6", credito, 6);
    paso(0, 1, 0, 0, 0);
    chk("d_sel1", sel, 1);
    paso(0, 0, 0, 0, 0);
    chk("d_sel1b", sel, 1);
    paso(0, 0, 0, 0, 0);
    paso(0, 0, 0, 1, 0);
    chk("d_cambio3", cambio, 3);
    chk("d_cv", cambio_valid, 1);
    paso(0, 0, 0, 0, 0);
    repeat (2) paso(3, 0, 0, 0, 0);
    paso(2, 0, 0, 0, 0);
    paso(2, 0, 0, 0, 0);
    chk("d_cred14", credito, 14);
    paso(1, 0, 0, 0, 0);
    chk("d_cred15", credito, 15);
    paso(0, 0, 1, 0, 0);
    paso(0, 0, 0, 0, 0);
    paso(2, 0, 0, 0, 0);
    paso(0, 4, 0, 0, 0);
    paso(0, 0, 1, 0, 0);
    chk("d_cancel2", cambio, 2);
    paso(2, 0, 0, 0, 0);
    paso(2, 0, 0, 0, 0);
    paso(1, 2, 0, 0, 0);
    repeat (3) paso(0, 0, 0, 0, 0);
    paso(0, 0, 0, 1, 0);
    chk("d_cambio0", cambio, 0);
    paso(0, 0, 0, 0, 0);
    paso(3, 0, 0, 0, 0);
    paso(0, 1, 0, 0, 0);
    repeat (3) paso(0, 0, 0, 0, 0);
    paso(0, 0, 0, 0, 1);
    chk("d_rst_sel", sel, 0);
    paso(0, 0, 0, 1, 0);
    paso(0, 0, 0, 0, 0);
`ifdef COBRO_TIMEOUT_EN
    paso(3, 0, 0, 0, 0);
    paso(0, 1, 0, 0, 0);
    repeat (13) paso(0, 0, 0, 0, 0);
    chk("d_falla", falla, 1);
    paso(0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 4000; i++) begin
      int m, b;
      m = $urandom_range(0, 1) ? $urandom_range(0, 3) : 0;
      b = $urandom_range(0, 9) < 7 ? 0 : $urandom_range(1, 7);
      paso(m, b, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
